// File: rtl/c_slice_pkg.sv
// Shared constants and types for the C-bus slice collector.
package c_slice_pkg;

  localparam int unsigned SLICE_W    = 12;
  localparam int unsigned NUM_SLICES = 3;

  // Slice 1 has no driver at the producer, so it is disabled by default.
  localparam logic [NUM_SLICES-1:0] SLICE_MASK_DEFAULT = 3'b101;

  typedef logic [SLICE_W-1:0] slice_t;
  typedef logic [1:0]         idx_t;

  typedef enum logic {IDLE, EMIT} state_t;

endpackage

// File: rtl/c_slice_collector_next_idx.sv
// Finds the next enabled slice above cur_idx (or the first one when from_start)
// and reports whether that slice is the last enabled one.
module c_slice_next_idx
  import c_slice_pkg::*;
#(
  parameter int unsigned           N_SLICES = c_slice_pkg::NUM_SLICES,
  parameter logic [N_SLICES-1:0]   MASK     = c_slice_pkg::SLICE_MASK_DEFAULT
) (
  input  logic       from_start,
  input  logic [1:0] cur_idx,
  output logic [1:0] next_idx,
  output logic       found,
  output logic       is_last
);

  logic more;

  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    more     = 1'b0;
    for (int unsigned i = 0; i < N_SLICES; i++) begin
      if (!found && MASK[i] && (from_start || i > 32'(cur_idx))) begin
        found    = 1'b1;
        next_idx = 2'(i);
      end
    end
    for (int unsigned i = 0; i < N_SLICES; i++) begin
      if (found && MASK[i] && i > 32'(next_idx)) begin
        more = 1'b1;
      end
    end
    is_last = found && !more;
  end

endmodule

// File: rtl/c_slice_collector.sv
// Captures the C result bus on request and streams its enabled 12-bit slices
// out one per beat over valid/ready, counting samples rejected while busy.
module c_slice_collector
  import c_slice_pkg::*;
#(
  parameter int unsigned             SLICE_W    = c_slice_pkg::SLICE_W,
  parameter int unsigned             NUM_SLICES = c_slice_pkg::NUM_SLICES,
  parameter logic [NUM_SLICES-1:0]   SLICE_MASK = c_slice_pkg::SLICE_MASK_DEFAULT,
  parameter int unsigned             CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [40:0]        c_bus,
  input  logic               sample_i,
  output logic               busy_o,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic [1:0]         out_idx,
  output logic               out_last,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int unsigned WORD_W = NUM_SLICES * SLICE_W;

  state_t             state, state_n;
  logic [WORD_W-1:0]  shadow, shadow_n;
  logic               valid_n, last_n;
  logic [SLICE_W-1:0] data_n;
  logic [1:0]         idx_n;
  logic [CNT_W-1:0]   cnt_n;

  logic       xfer, accept, drop;
  logic [1:0] first_idx, nxt_idx;
  logic       first_found, first_last, nxt_found, nxt_last;

  logic unused_c_hi;
  assign unused_c_hi = ^c_bus[40:WORD_W];

  function automatic logic [SLICE_W-1:0] pick(input logic [WORD_W-1:0] w,
                                              input logic [1:0] idx);
    logic [SLICE_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (32'(idx) == i) s = w[i*SLICE_W +: SLICE_W];
    end
    return s;
  endfunction

  c_slice_next_idx #(.N_SLICES(NUM_SLICES), .MASK(SLICE_MASK)) u_first (
    .from_start (1'b1),
    .cur_idx    (2'b00),
    .next_idx   (first_idx),
    .found      (first_found),
    .is_last    (first_last)
  );

  c_slice_next_idx #(.N_SLICES(NUM_SLICES), .MASK(SLICE_MASK)) u_next (
    .from_start (1'b0),
    .cur_idx    (out_idx),
    .next_idx   (nxt_idx),
    .found      (nxt_found),
    .is_last    (nxt_last)
  );

  assign xfer   = out_valid && out_ready;
  // first_found is false only for an all-zero mask, which disables sampling.
  assign accept = first_found && sample_i && (state == IDLE || (xfer && out_last));
  assign drop   = first_found && sample_i && !accept;
  assign busy_o = (state == EMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      shadow    <= shadow_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      out_idx   <= idx_n;
      out_last  <= last_n;
      drop_cnt  <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    valid_n  = out_valid;
    data_n   = out_data;
    idx_n    = out_idx;
    last_n   = out_last;
    cnt_n    = drop_cnt;

    // The first beat is taken straight from c_bus because shadow only
    // updates on this same edge.
    if (accept) begin
      state_n  = EMIT;
      shadow_n = c_bus[WORD_W-1:0];
      valid_n  = 1'b1;
      idx_n    = first_idx;
      data_n   = pick(c_bus[WORD_W-1:0], first_idx);
      last_n   = first_last;
    end else if (xfer) begin
      if (out_last || !nxt_found) begin
        state_n = IDLE;
        valid_n = 1'b0;
        data_n  = '0;
        idx_n   = '0;
        last_n  = 1'b0;
      end else begin
        idx_n  = nxt_idx;
        data_n = pick(shadow, nxt_idx);
        last_n = nxt_last;
      end
    end

    if (drop && drop_cnt != '1) begin
      cnt_n = drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_c_slice_collector.sv
// Directed bench for c_slice_collector with a beat-queue reference model.
module tb_c_slice_collector;

  localparam logic [2:0] MASK = 3'b101;

  logic        clk, rst_n;
  logic [40:0] c_bus;
  logic        sample_i, out_ready;
  logic        busy_o, out_valid, out_last;
  logic [11:0] out_data;
  logic [1:0]  out_idx;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  c_slice_collector #(
    .SLICE_W    (12),
    .NUM_SLICES (3),
    .SLICE_MASK (MASK),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_bus     (c_bus),
    .sample_i  (sample_i),
    .busy_o    (busy_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds the beats of the word still to be
  // delivered; its head is the beat that must be on the outputs.
  typedef struct {
    logic [1:0]  idx;
    logic [11:0] data;
    logic        last;
  } beat_t;

  beat_t m_q[$];
  int    m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      bit m_valid, m_xfer, m_acc;
      m_valid = (m_q.size() > 0);
      m_xfer  = m_valid && out_ready;
      m_acc   = (MASK != 0) && sample_i && (!m_valid || (m_xfer && m_q.size() == 1));
      if (m_xfer) void'(m_q.pop_front());
      if (m_acc) begin
        for (int i = 0; i < 3; i++) begin
          if (MASK[i]) begin
            beat_t b;
            b.idx  = 2'(i);
            b.data = c_bus[i*12 +: 12];
            b.last = 1'b0;
            m_q.push_back(b);
          end
        end
        m_q[m_q.size()-1].last = 1'b1;
      end else if ((MASK != 0) && sample_i) begin
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
      check("busy", {31'b0, busy_o}, {31'b0, m_q.size() > 0});
      check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
      if (m_q.size() > 0 && out_valid) begin
        check("data", 32'(out_data), 32'(m_q[0].data));
        check("idx", 32'(out_idx), 32'(m_q[0].idx));
        check("last", {31'b0, out_last}, {31'b0, m_q[0].last});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  localparam logic [40:0] WORD1 = {5'h1F, 12'h5C3, 12'h123, 12'hA5A};
  localparam logic [40:0] WORD2 = {5'h00, 12'h777, 12'h456, 12'h0FF};

  initial begin
    rst_n = 1'b0; c_bus = '0; sample_i = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_cnt", 32'(drop_cnt), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic word, sink always ready.
    c_bus = WORD1; sample_i = 1'b1; out_ready = 1'b1;
    step(); sample_i = 1'b0;
    @(negedge clk);
    check("t1_b0_valid", {31'b0, out_valid}, 32'd1);
    check("t1_b0_idx", 32'(out_idx), 32'd0);
    check("t1_b0_data", 32'(out_data), 32'hA5A);
    check("t1_b0_last", {31'b0, out_last}, 32'd0);
    step();
    @(negedge clk);
    check("t1_b1_idx", 32'(out_idx), 32'd2);
    check("t1_b1_data", 32'(out_data), 32'h5C3);
    check("t1_b1_last", {31'b0, out_last}, 32'd1);
    step();
    @(negedge clk);
    check("t1_idle_valid", {31'b0, out_valid}, 32'd0);
    check("t1_idle_busy", {31'b0, busy_o}, 32'd0);

    // Back-pressure: first beat held for 5 cycles.
    step();
    out_ready = 1'b0; sample_i = 1'b1;
    step(); sample_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_hold_valid", {31'b0, out_valid}, 32'd1);
      check("t2_hold_data", 32'(out_data), 32'hA5A);
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("t2_b1_data", 32'(out_data), 32'h5C3);
    step(); step();

    // c_bus changes after capture.
    c_bus = WORD1; sample_i = 1'b1;
    step(); sample_i = 1'b0; c_bus = '1;
    @(negedge clk);
    check("t3_b0_data", 32'(out_data), 32'hA5A);
    step();
    @(negedge clk);
    check("t3_b1_data", 32'(out_data), 32'h5C3);
    step(); step();

    // Drops while stalled, then saturation.
    c_bus = WORD1; out_ready = 1'b0; sample_i = 1'b1;
    step(); sample_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_i = 1'b1; step();
      sample_i = 1'b0; step();
    end
    @(negedge clk);
    check("t4_drop3", 32'(drop_cnt), 32'd3);
    check("t4_data_kept", 32'(out_data), 32'hA5A);
    sample_i = 1'b1;
    repeat (300) step();
    sample_i = 1'b0;
    @(negedge clk);
    check("t4_drop_sat", 32'(drop_cnt), 32'd255);
    out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check("t4_drained", {31'b0, out_valid}, 32'd0);

    // Back-to-back: new sample on the last-beat handshake.
    c_bus = WORD1; sample_i = 1'b1;
    step(); sample_i = 1'b0;
    step();
    @(negedge clk);
    check("t5_last_pres", {31'b0, out_last}, 32'd1);
    c_bus = WORD2; sample_i = 1'b1;
    step(); sample_i = 1'b0;
    @(negedge clk);
    check("t5_b2b_valid", {31'b0, out_valid}, 32'd1);
    check("t5_b2b_idx", 32'(out_idx), 32'd0);
    check("t5_b2b_data", 32'(out_data), 32'h0FF);
    check("t5_cnt_same", 32'(drop_cnt), 32'd255);
    step();
    @(negedge clk);
    check("t5_b2b_hi", 32'(out_data), 32'h777);
    step(); step();

    // Reset mid-word while stalled.
    c_bus = WORD1; out_ready = 1'b0; sample_i = 1'b1;
    step(); sample_i = 1'b0;
    @(negedge clk);
    check("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'b0, out_valid}, 32'd0);
    check("t6_async_busy", {31'b0, busy_o}, 32'd0);
    out_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      @(negedge clk);
      check("t6_no_stale", {31'b0, out_valid}, 32'd0);
      check("t6_cnt_clear", 32'(drop_cnt), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/c_slice_collector.md
Name: c_slice_collector

Overview:
Downstream stage of the three-slice 12-bit inverter/OAI array. It samples the 41-bit C result bus on command and streams the populated 12-bit slices out one per beat over a valid/ready interface, tagging each beat with its slice index. Slice 1 is unconnected at the producer, so it is masked off by parameter. Bits 40:36 are never driven and are ignored.

Parameters:
SLICE_W, 12, width of one slice.
NUM_SLICES, 3, slices carried on c_bus; c_bus width is 41, and slices occupy bits [NUM_SLICES*SLICE_W-1:0].
SLICE_MASK, 3'b101, bit i set means slice i is emitted.
CNT_W, 8, width of the saturating drop counter.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
c_bus  in  41  result bus from the slice array; bits 40:36 are ignored.
sample_i  in  1  single-cycle capture request.
busy_o  out  1  high while a captured word is being emitted.
out_valid  out  1  a beat is presented.
out_ready  in  1  sink accepts the beat.
out_data  out  12  slice payload.
out_idx  out  2  slice index, 0..NUM_SLICES-1.
out_last  out  1  final enabled slice of the current word.
drop_cnt  out  CNT_W  count of rejected samples, saturating.

Behaviour:
- Reset (async assert, sync release): state IDLE. out_valid, out_data, out_idx, out_last and busy_o are 0. drop_cnt is 0. Shadow register is 0.
- States are IDLE and EMIT.
- Accept condition: sample_i && (state==IDLE || (out_valid && out_ready && out_last)).
- On accept, c_bus[35:0] is latched into the shadow register in the same edge. The state becomes EMIT, and out_valid rises on the next cycle with the lowest enabled slice. Latency from sample to first beat is 1 cycle.
- sample_i while in EMIT without a concurrent last handshake is dropped. drop_cnt increments and saturates at 2^CNT_W-1. The shadow register is unchanged.
- If SLICE_MASK==0, sample_i is ignored: no state change and no count.
- Handshake: a beat transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_idx and out_last hold stable.
  - out_valid never drops without a transfer.
- On a transfer of a non-last beat, the next cycle presents the next higher enabled slice. Masked slices cost no cycles, so the default config emits idx 0 then idx 2.
- On a transfer of the last beat:
  - If accept is also true that cycle, stay in EMIT and present the first slice of the new word next cycle (back-to-back, no bubble).
  - Otherwise go to IDLE and out_valid goes to 0.
- busy_o = (state==EMIT).
- The c_bus value is sampled only on accept. Later changes to c_bus do not affect the word in flight.
- Reset asserted mid-word: all outputs clear immediately, and the partial word is discarded with no further beats.

Decomposition:
- Shared package c_slice_pkg holds:
  - the SLICE_W and NUM_SLICES constants;
  - typedef slice_t (logic [SLICE_W-1:0]);
  - typedef idx_t (logic [1:0]);
  - the state enum {IDLE, EMIT};
  - the default SLICE_MASK.
- One natural sub-module is c_slice_next_idx: combinational "next enabled index above i" and "is last enabled" from SLICE_MASK. It is reused to pick the first slice (search from -1).
- The top holds the FSM, shadow register, output register and counter.

Test Plan:
- Reset, then sample_i with c_bus[11:0]=12'hA5A, [23:12]=12'h123, [35:24]=12'h5C3, out_ready=1. Beats are (idx0, 12'hA5A, last=0) then (idx2, 12'h5C3, last=1), first beat 1 cycle after sample. 12'h123 never appears. busy_o then falls.
- Same stimulus with out_ready held 0 for 5 cycles. out_valid stays 1 with data 12'hA5A constant, and transfer happens only once ready rises.
- Change c_bus to all-ones one cycle after sample. The emitted data is still 12'hA5A and 12'h5C3.
- Pulse sample_i three times during EMIT with no last handshake. drop_cnt==3. Drive 300 drops: drop_cnt==255.
- Assert sample_i in the cycle of the last-beat handshake with new c_bus[11:0]=12'h0FF. The next cycle presents idx0, 12'h0FF with no idle gap, and drop_cnt is unchanged.
- Assert rst_n=0 while idx0 is stalled. out_valid and busy_o go to 0 asynchronously. After release, no stale beat appears.
